// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RISC-V style loads and stores into word accesses
// on a backend with one-cycle read latency. Sub-word stores use read-modify-write.
// Optional build macro LSU_MISALIGN_CHECK_EN: reject misaligned halfword/word accesses
// with respError instead of forcing alignment.
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [2:0]  reqFunct3,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respError,
    output logic [29:0] backendAddress,
    output logic [31:0] backendDataIn,
    output logic        backendWriteEnable,
    input  logic [31:0] backendDataOut
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StMerge,
        StWrite,
        StResp
    } state_e;

    state_e      state_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic        we_q;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic        req_err;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Decode whether an incoming request completes immediately with an error
    always_comb begin
        req_illegal = 1'b0;
        if (reqWrite) begin
            req_illegal = (reqFunct3 > 3'b010);
        end else begin
            req_illegal = (reqFunct3 == 3'b011) || (reqFunct3 == 3'b110) ||
                          (reqFunct3 == 3'b111);
        end
`ifdef LSU_MISALIGN_CHECK_EN
        req_misaligned = ((reqFunct3[1:0] == 2'b01) && reqAddress[0]) ||
                         ((reqFunct3[1:0] == 2'b10) && (reqAddress[1:0] != 2'b00));
`else
        req_misaligned = 1'b0;
`endif
        req_err = req_illegal || req_misaligned;
    end

    // Control FSM; all control outputs are registered alongside the state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            we_q         <= 1'b0;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
        end else begin
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            we_q         <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (reqValid) begin
                        write_q  <= reqWrite;
                        funct3_q <= reqFunct3;
                        addr_q   <= reqAddress;
                        wdata_q  <= reqWriteData;
                        if (req_err) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                        end else if (reqWrite && (reqFunct3 == 3'b010)) begin
                            state_q <= StWrite;
                            we_q    <= 1'b1;
                        end else begin
                            state_q <= StRead;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StRead: begin
                    if (write_q) begin
                        state_q <= StMerge;
                        we_q    <= 1'b1;
                    end else begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                    end
                end
                StMerge, StWrite: begin
                    state_q      <= StResp;
                    resp_valid_q <= 1'b1;
                end
                StResp: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Lane selection on the returned word (halfword lane by address[1])
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_v = backendDataOut[7:0];
            2'b01:   byte_v = backendDataOut[15:8];
            2'b10:   byte_v = backendDataOut[23:16];
            default: byte_v = backendDataOut[31:24];
        endcase
        half_v = addr_q[1] ? backendDataOut[31:16] : backendDataOut[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b010:  load_data = backendDataOut;
            3'b100:  load_data = {24'h0, byte_v};
            3'b101:  load_data = {16'h0, half_v};
            default: load_data = 32'h0;
        endcase
    end

    // Read-modify-write: replace only the addressed byte/halfword of the old word
    always_comb begin
        merged = backendDataOut;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Output drive; data paths follow the backend combinationally since read data
    // only arrives in the cycle it is consumed
    always_comb begin
        reqReady           = ready_q;
        respValid          = resp_valid_q;
        respError          = resp_error_q;
        respData           = (resp_valid_q && !resp_error_q && !write_q) ? load_data : 32'h0;
        backendAddress     = addr_q[31:2];
        backendWriteEnable = we_q;
        if (state_q == StWrite) begin
            backendDataIn = wdata_q;
        end else if (state_q == StMerge) begin
            backendDataIn = merged;
        end else begin
            backendDataIn = 32'h0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a response scoreboard.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic [29:0] backendAddress;
    logic [31:0] backendDataIn;
    logic        backendWriteEnable;
    logic [31:0] backendDataOut;

    load_store_unit dut (
        .clock              (clock),
        .reset              (reset),
        .reqValid           (reqValid),
        .reqReady           (reqReady),
        .reqWrite           (reqWrite),
        .reqFunct3          (reqFunct3),
        .reqAddress         (reqAddress),
        .reqWriteData       (reqWriteData),
        .respValid          (respValid),
        .respData           (respData),
        .respError          (respError),
        .backendAddress     (backendAddress),
        .backendDataIn      (backendDataIn),
        .backendWriteEnable (backendWriteEnable),
        .backendDataOut     (backendDataOut)
    );

    always #5 clock = ~clock;

    // Memory model: synchronous read, data valid one cycle after the address
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = 6'd0;
    logic [31:0] pre_data = 32'h0;
    int          wr_count = 0;
    logic [29:0] wr_addr = 30'h0;
    logic [31:0] wr_data = 32'h0;

    always @(posedge clock) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (backendWriteEnable === 1'b1) begin
            mem[backendAddress[5:0]] <= backendDataIn;
            wr_count <= wr_count + 1;
            wr_addr  <= backendAddress;
            wr_data  <= backendDataIn;
        end
        backendDataOut <= mem[backendAddress[5:0]];
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, scoreboard its response, and check the write count it caused
    task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int exp_nwr);
        exp_t e;
        exp_t got;
        int   wr_before;
        int   k;
        bit   seen;
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = exp_lat;
        sb.push_back(e);
        @(negedge clock);
        wr_before    = wr_count;
        check({tag, "_ready"}, {31'h0, reqReady}, 32'h1);
        reqValid     = 1'b1;
        reqWrite     = wr;
        reqFunct3    = f3;
        reqAddress   = addr;
        reqWriteData = wdata;
        @(posedge clock);
        #1 reqValid = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 8) begin
            @(negedge clock);
            k++;
            if (respValid === 1'b1) begin
                seen = 1'b1;
                check({tag, "_sb_size"}, sb.size(), 32'd1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check({tag, "_data"}, respData, got.data);
                    check({tag, "_err"}, {31'h0, respError}, {31'h0, got.err});
                    check({tag, "_lat"}, k, got.lat);
                end
            end else begin
                check({tag, "_idle_data"}, respData, 32'h0);
            end
        end
        check({tag, "_resp_seen"}, {31'h0, seen}, 32'h1);
        check({tag, "_nwr"}, wr_count - wr_before, exp_nwr);
    endtask

    initial begin
        int wr_snap;
        reset        = 1'b1;
        reqValid     = 1'b1;
        reqWrite     = 1'b0;
        reqFunct3    = 3'b010;
        reqAddress   = 32'h14;
        reqWriteData = 32'h0;

        // Reset with reqValid high; preload memory meanwhile
        pre_we   = 1'b1;
        pre_addr = 6'd5;
        pre_data = 32'h8899AABB;
        @(posedge clock);
        #1 pre_addr = 6'd8;
        pre_data = 32'h0;
        @(posedge clock);
        #1 pre_we = 1'b0;
        @(negedge clock);
        check("rst_ready", {31'h0, reqReady}, 32'h1);
        check("rst_valid", {31'h0, respValid}, 32'h0);
        check("rst_error", {31'h0, respError}, 32'h0);
        check("rst_data", respData, 32'h0);
        check("rst_we", {31'h0, backendWriteEnable}, 32'h0);
        check("rst_baddr", {2'b0, backendAddress}, 32'h0);
        check("rst_bdin", backendDataIn, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        reqValid = 1'b0;
        @(negedge clock);
        check("post_rst_ready", {31'h0, reqReady}, 32'h1);
        check("post_rst_valid", {31'h0, respValid}, 32'h0);

        // Loads on word 5 = 0x8899AABB
        do_req("lb",  1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0);
        do_req("lbu", 1'b0, 3'b100, 32'h17, 32'h0, 32'h00000088, 1'b0, 2, 0);
        do_req("lh",  1'b0, 3'b001, 32'h14, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);
        do_req("lhu", 1'b0, 3'b101, 32'h16, 32'h0, 32'h00008899, 1'b0, 2, 0);
        do_req("lw5", 1'b0, 3'b010, 32'h14, 32'h0, 32'h8899AABB, 1'b0, 2, 0);

        // Byte store via read-modify-write
        do_req("sb",  1'b1, 3'b000, 32'h15, 32'h000000CC, 32'h0, 1'b0, 3, 1);
        check("sb_waddr", {2'b0, wr_addr}, 32'd5);
        check("sb_wdata", wr_data, 32'h8899CCBB);
        do_req("lw5b", 1'b0, 3'b010, 32'h14, 32'h0, 32'h8899CCBB, 1'b0, 2, 0);

        // Word store and readback
        do_req("sw",  1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        check("sw_waddr", {2'b0, wr_addr}, 32'd8);
        check("sw_wdata", wr_data, 32'hDEADBEEF);
        do_req("lw8", 1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

        // Upper halfword store
        do_req("sh",  1'b1, 3'b001, 32'h22, 32'h00001234, 32'h0, 1'b0, 3, 1);
        check("sh_wdata", wr_data, 32'h1234BEEF);
        do_req("lw8b", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1234BEEF, 1'b0, 2, 0);

        // Illegal funct3 in either build
        do_req("ld011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("st100", 1'b1, 3'b100, 32'h20, 32'h55, 32'h0, 1'b1, 1, 0);

        // Misaligned accesses
`ifdef LSU_MISALIGN_CHECK_EN
        do_req("lw_mis", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("lh_mis", 1'b0, 3'b001, 32'h17, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("sw_mis", 1'b1, 3'b010, 32'h21, 32'h0BAD0BAD, 32'h0, 1'b1, 1, 0);
`else
        do_req("lw_mis", 1'b0, 3'b010, 32'h22, 32'h0, 32'h1234BEEF, 1'b0, 2, 0);
        do_req("lh_mis", 1'b0, 3'b001, 32'h17, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
`endif

        // Reset during the MERGE of a byte store
        @(negedge clock);
        reqValid     = 1'b1;
        reqWrite     = 1'b1;
        reqFunct3    = 3'b000;
        reqAddress   = 32'h14;
        reqWriteData = 32'h77;
        @(posedge clock);
        #1 reqValid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("abort_in_merge", {31'h0, backendWriteEnable}, 32'h1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wr_snap = wr_count;
        check("abort_we", {31'h0, backendWriteEnable}, 32'h0);
        check("abort_valid", {31'h0, respValid}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_ready", {31'h0, reqReady}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort_no_resp", {31'h0, respValid}, 32'h0);
        end
        check("abort_no_write", wr_count - wr_snap, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
